mips_multicycle_ctrl: RTL

//  Main control FSM for the multi-cycle MIPS datapath. It drives the 3-bit ALU op select and every datapath enable/mux.

---
 rtl/mips_ctrl_pkg.sv | 85 ++++++++
 rtl/mips_alu_decoder.sv | 26 ++
 rtl/mips_multicycle_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state codes, opcodes,
// funct codes, ALU op select values and datapath mux encodings.
package mips_ctrl_pkg;

    localparam int unsigned STATE_CODE_W = 4;

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMRD    = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWR    = 4'd6;
    localparam logic [3:0] S_RTYPE_EX = 4'd7;
    localparam logic [3:0] S_ALU_WB   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_IMM_EX   = 4'd10;
    localparam logic [3:0] S_IMM_WB   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Per-state control word; branch_eq/branch_ne qualify pc_en with the zero flag.
    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational R-type funct decoder producing the ALU op select and a valid flag.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_XOR:  alu_ctrl = ALU_XOR;
            FN_NOR:  alu_ctrl = ALU_NOR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_SRL:  alu_ctrl = ALU_SRL;
            default: valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: Moore decode of the state
// register into datapath enables/mux selects, with pc_en qualified by zero in BRANCH.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned EXT_ISA = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               zero_ext,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_ctrl,
    output logic [STATE_W-1:0] state_o,
    output logic               illegal
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [2:0]         w_fn_alu;
    logic               w_fn_valid;
    logic               w_ext;
    logic               w_is_imm;
    logic               w_is_branch;
    ctrl_t              w_ctrl;

    assign w_ext       = (EXT_ISA != 0);
    assign w_is_imm    = (op == OP_ADDI) || (w_ext && ((op == OP_ANDI) || (op == OP_ORI)));
    assign w_is_branch = (op == OP_BEQ) || (w_ext && (op == OP_BNE));

    mips_alu_decoder u_alu_dec (
        .funct    (funct),
        .alu_ctrl (w_fn_alu),
        .valid    (w_fn_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STATE_W'(S_RST);
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = STATE_W'(S_RST);
        case (r_state)
            STATE_W'(S_RST):    w_next = STATE_W'(S_FETCH);
            STATE_W'(S_FETCH):  w_next = STATE_W'(S_DECODE);
            STATE_W'(S_DECODE): begin
                if ((op == OP_LW) || (op == OP_SW)) begin
                    w_next = STATE_W'(S_MEMADR);
                end else if (op == OP_RTYPE) begin
                    w_next = STATE_W'(S_RTYPE_EX);
                end else if (w_is_branch) begin
                    w_next = STATE_W'(S_BRANCH);
                end else if (w_is_imm) begin
                    w_next = STATE_W'(S_IMM_EX);
                end else if (op == OP_J) begin
                    w_next = STATE_W'(S_JUMP);
                end else begin
                    w_next = STATE_W'(S_TRAP);
                end
            end
            STATE_W'(S_MEMADR):   w_next = (op == OP_LW) ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
            STATE_W'(S_MEMRD):    w_next = STATE_W'(S_MEMWB);
            STATE_W'(S_MEMWB):    w_next = STATE_W'(S_FETCH);
            STATE_W'(S_MEMWR):    w_next = STATE_W'(S_FETCH);
            STATE_W'(S_RTYPE_EX): w_next = w_fn_valid ? STATE_W'(S_ALU_WB) : STATE_W'(S_TRAP);
            STATE_W'(S_ALU_WB):   w_next = STATE_W'(S_FETCH);
            STATE_W'(S_BRANCH):   w_next = STATE_W'(S_FETCH);
            STATE_W'(S_IMM_EX):   w_next = STATE_W'(S_IMM_WB);
            STATE_W'(S_IMM_WB):   w_next = STATE_W'(S_FETCH);
            STATE_W'(S_JUMP):     w_next = STATE_W'(S_FETCH);
            STATE_W'(S_TRAP):     w_next = STATE_W'(S_TRAP);
            default:              w_next = STATE_W'(S_RST);
        endcase
    end

    always_comb begin
        w_ctrl = ctrl_idle();
        case (r_state)
            STATE_W'(S_FETCH): begin
                w_ctrl.ir_write  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.pc_src    = PCSRC_ALU;
                w_ctrl.pc_write  = 1'b1;
            end
            STATE_W'(S_DECODE): begin
                w_ctrl.alu_src_b = SRCB_BRIMM;
            end
            STATE_W'(S_MEMADR): begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMRD): begin
                w_ctrl.iord = 1'b1;
            end
            STATE_W'(S_MEMWB): begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            STATE_W'(S_MEMWR): begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            STATE_W'(S_RTYPE_EX): begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_ctrl  = w_fn_alu;
            end
            STATE_W'(S_ALU_WB): begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            STATE_W'(S_BRANCH): begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_ctrl  = ALU_SUB;
                w_ctrl.pc_src    = PCSRC_ALUOUT;
                w_ctrl.branch_eq = (op == OP_BEQ);
                w_ctrl.branch_ne = w_ext && (op == OP_BNE);
            end
            STATE_W'(S_IMM_EX): begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                if (w_ext && (op == OP_ANDI)) begin
                    w_ctrl.alu_ctrl = ALU_AND;
                    w_ctrl.zero_ext = 1'b1;
                end else if (w_ext && (op == OP_ORI)) begin
                    w_ctrl.alu_ctrl = ALU_OR;
                    w_ctrl.zero_ext = 1'b1;
                end
            end
            STATE_W'(S_IMM_WB): begin
                w_ctrl.reg_write = 1'b1;
            end
            STATE_W'(S_JUMP): begin
                w_ctrl.pc_src   = PCSRC_JUMP;
                w_ctrl.pc_write = 1'b1;
            end
            STATE_W'(S_TRAP): begin
                w_ctrl.illegal = 1'b1;
            end
            default: w_ctrl = ctrl_idle();
        endcase
    end

    assign pc_en      = w_ctrl.pc_write | (w_ctrl.branch_eq & zero) | (w_ctrl.branch_ne & ~zero);
    assign iord       = w_ctrl.iord;
    assign mem_write  = w_ctrl.mem_write;
    assign ir_write   = w_ctrl.ir_write;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign reg_write  = w_ctrl.reg_write;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign zero_ext   = w_ctrl.zero_ext;
    assign pc_src     = w_ctrl.pc_src;
    assign alu_ctrl   = w_ctrl.alu_ctrl;
    assign illegal    = w_ctrl.illegal;
    assign state_o    = r_state;

endmodule
